// File: rtl/uart_cmd_sequencer.sv
// Frames uart_rx bytes into SYNC/ADDR/DATA[/CSUM] phase commands and issues write, commit or error strobes.
// Optional macro UART_CMD_CHECKSUM_EN adds a trailing XOR checksum byte to every packet.
module uart_cmd_sequencer #(
  parameter int unsigned NUM_CHANNELS   = 64,
  parameter int unsigned ADDR_WIDTH     = 6,
  parameter logic [7:0]  SYNC_BYTE      = 8'hAA,
  parameter logic [7:0]  COMMIT_ADDR    = 8'hFF,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  rx_done_in,
  input  logic [7:0]            rx_byte_in,
  output logic                  wr_en_out,
  output logic [ADDR_WIDTH-1:0] wr_addr_out,
  output logic [7:0]            wr_data_out,
  output logic                  commit_out,
  output logic                  error_out,
  output logic [7:0]            error_count_out,
  output logic                  busy_out
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_CSUM, ST_EXEC} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_EXEC} state_t;
`endif

  state_t            state_q, state_d;
  logic              rx_done_q;
  logic              strb;
  logic              in_pkt;
  logic              timeout;
  logic              pkt_bad;
  logic [7:0]        addr_q;
  logic [7:0]        data_q;
  logic [CNT_W-1:0]  cnt_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  logic                  wr_en_d, commit_d, error_d;
  logic [ADDR_WIDTH-1:0] wr_addr_d;
  logic [7:0]            wr_data_d;
  logic [7:0]            error_count_d;

  assign strb     = rx_done_in & ~rx_done_q;
  assign in_pkt   = (state_q != ST_IDLE) && (state_q != ST_EXEC);
  // A byte arriving on the last allowed cycle beats the timeout.
  assign timeout  = in_pkt && !strb && (cnt_q == TIMEOUT_LAST);
  assign busy_out = (state_q != ST_IDLE);

`ifdef UART_CMD_CHECKSUM_EN
  assign pkt_bad = ((32'(addr_q) >= NUM_CHANNELS) && (addr_q != COMMIT_ADDR)) ||
                   (csum_q != (SYNC_BYTE ^ addr_q ^ data_q));
`else
  assign pkt_bad = (32'(addr_q) >= NUM_CHANNELS) && (addr_q != COMMIT_ADDR);
`endif

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (strb && (rx_byte_in == SYNC_BYTE)) state_d = ST_ADDR;
      ST_ADDR: begin
        if (strb)         state_d = ST_DATA;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_DATA: begin
`ifdef UART_CMD_CHECKSUM_EN
        if (strb)         state_d = ST_CSUM;
`else
        if (strb)         state_d = ST_EXEC;
`endif
        else if (timeout) state_d = ST_IDLE;
      end
`ifdef UART_CMD_CHECKSUM_EN
      ST_CSUM: begin
        if (strb)         state_d = ST_EXEC;
        else if (timeout) state_d = ST_IDLE;
      end
`endif
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered command outputs.
  always_comb begin
    wr_en_d       = 1'b0;
    commit_d      = 1'b0;
    error_d       = 1'b0;
    wr_addr_d     = wr_addr_out;
    wr_data_d     = wr_data_out;
    error_count_d = error_count_out;
    if (state_q == ST_EXEC) begin
      if (pkt_bad) begin
        error_d = 1'b1;
      end else if (addr_q == COMMIT_ADDR) begin
        commit_d = 1'b1;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = addr_q[ADDR_WIDTH-1:0];
        wr_data_d = data_q;
      end
    end
    if (timeout) error_d = 1'b1;
    if (error_d && (error_count_out != 8'hFF)) error_count_d = error_count_out + 8'd1;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      wr_en_out       <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= 8'h00;
      commit_out      <= 1'b0;
      error_out       <= 1'b0;
      error_count_out <= 8'h00;
    end else begin
      wr_en_out       <= wr_en_d;
      wr_addr_out     <= wr_addr_d;
      wr_data_out     <= wr_data_d;
      commit_out      <= commit_d;
      error_out       <= error_d;
      error_count_out <= error_count_d;
    end
  end

  // Byte capture, edge detect and inter-byte timeout counter.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      rx_done_q <= 1'b0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      cnt_q     <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      csum_q    <= 8'h00;
`endif
    end else begin
      rx_done_q <= rx_done_in;
      if (strb) begin
        if (state_q == ST_ADDR) addr_q <= rx_byte_in;
        if (state_q == ST_DATA) data_q <= rx_byte_in;
`ifdef UART_CMD_CHECKSUM_EN
        if (state_q == ST_CSUM) csum_q <= rx_byte_in;
`endif
      end
      if ((state_q == ST_IDLE) || strb) cnt_q <= '0;
      else if (in_pkt)                  cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Bench for uart_cmd_sequencer: packet-level reference model checked every cycle plus directed literal checks.
// Honours UART_CMD_CHECKSUM_EN the same way as the design.
module tb_uart_cmd_sequencer;

  localparam int unsigned T = 4096;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif

  logic       clock_in   = 1'b0;
  logic       reset_in   = 1'b1;
  logic       rx_done_in = 1'b0;
  logic [7:0] rx_byte_in = 8'h00;
  logic       wr_en_out, commit_out, error_out, busy_out;
  logic [5:0] wr_addr_out;
  logic [7:0] wr_data_out, error_count_out;

  uart_cmd_sequencer dut (
    .clock_in(clock_in), .reset_in(reset_in), .rx_done_in(rx_done_in), .rx_byte_in(rx_byte_in),
    .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out),
    .commit_out(commit_out), .error_out(error_out), .error_count_out(error_count_out),
    .busy_out(busy_out)
  );

  always #5 clock_in = ~clock_in;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int obs_wr = 0, obs_commit = 0, obs_err = 0;
  int last_strb_cyc = 0, last_wr_cyc = 0, last_err_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Packet-level reference model: a byte list per packet and a silence counter.
  bit         m_done_prev = 1'b0;
  int         m_len = 0;
  int         m_gap = 0;
  bit         m_exec = 1'b0;
  logic [7:0] m_bytes [4];
  bit         exp_wr = 0, exp_commit = 0, exp_err = 0;
  logic [5:0] exp_addr = 6'd0;
  logic [7:0] exp_data = 8'd0;
  int         exp_cnt = 0;

  always @(posedge clock_in) begin
    bit strb;
    bit invalid;
    logic [7:0] a, d;
    strb = rx_done_in && !m_done_prev;
    cyc++;
    exp_wr = 0; exp_commit = 0; exp_err = 0;
    if (reset_in) begin
      m_done_prev = 1'b0; m_len = 0; m_gap = 0; m_exec = 1'b0;
      exp_addr = 6'd0; exp_data = 8'd0; exp_cnt = 0;
    end else begin
      m_done_prev = rx_done_in;
      if (m_exec) begin
        a = m_bytes[1]; d = m_bytes[2];
        invalid = (a >= 8'd64) && (a != 8'hFF);
`ifdef UART_CMD_CHECKSUM_EN
        if (m_bytes[3] != (8'hAA ^ a ^ d)) invalid = 1;
`endif
        if (invalid) exp_err = 1;
        else if (a == 8'hFF) exp_commit = 1;
        else begin exp_wr = 1; exp_addr = a[5:0]; exp_data = d; end
        m_exec = 1'b0; m_len = 0;
      end else if (m_len > 0) begin
        if (strb) begin
          m_bytes[m_len] = rx_byte_in;
          m_len++;
          m_gap = 0;
          if (m_len == NB) m_exec = 1'b1;
        end else if (m_gap == int'(T) - 1) begin
          exp_err = 1; m_len = 0;
        end else begin
          m_gap++;
        end
      end else if (strb && rx_byte_in == 8'hAA) begin
        m_bytes[0] = rx_byte_in; m_len = 1; m_gap = 0;
      end
      if (exp_err && exp_cnt < 255) exp_cnt++;
    end
    #1;
    check("wr_en", 32'(wr_en_out), 32'(exp_wr));
    check("commit", 32'(commit_out), 32'(exp_commit));
    check("error", 32'(error_out), 32'(exp_err));
    check("err_count", 32'(error_count_out), 32'(exp_cnt));
    check("busy", 32'(busy_out), 32'(m_len > 0));
    check("wr_addr", 32'(wr_addr_out), 32'(exp_addr));
    check("wr_data", 32'(wr_data_out), 32'(exp_data));
    if (wr_en_out)  begin obs_wr++; last_wr_cyc = cyc; end
    if (commit_out) obs_commit++;
    if (error_out)  begin obs_err++; last_err_cyc = cyc; end
  end

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clock_in);
    rx_byte_in = b;
    rx_done_in = 1'b1;
    last_strb_cyc = cyc + 1;
    repeat (hold) @(negedge clock_in);
    rx_done_in = 1'b0;
    repeat (gap - 1) @(negedge clock_in);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [7:0] d, input int hold, input int gap);
    send_byte(8'hAA, hold, gap);
    send_byte(a, hold, gap);
    send_byte(d, hold, gap);
`ifdef UART_CMD_CHECKSUM_EN
    send_byte(8'hAA ^ a ^ d, hold, gap);
`endif
  endtask

  task automatic settle();
    repeat (4) @(negedge clock_in);
  endtask

  int w0, c0, e0;
  task automatic snap();
    w0 = obs_wr; c0 = obs_commit; e0 = obs_err;
  endtask

  initial begin
    repeat (3) @(negedge clock_in);
    check("rst_wr_en", 32'(wr_en_out), 0);
    check("rst_err_count", 32'(error_count_out), 0);
    check("rst_busy", 32'(busy_out), 0);
    reset_in = 1'b0;
    settle();

    snap();
    send_pkt(8'h05, 8'h7F, 127, 10);
    settle();
    check("write_pulses", 32'(obs_wr - w0), 1);
    check("write_addr", 32'(wr_addr_out), 32'h05);
    check("write_data", 32'(wr_data_out), 32'h7F);
    check("write_errcnt", 32'(error_count_out), 0);
    check("write_latency", 32'(last_wr_cyc - last_strb_cyc), 1);

    snap();
    send_pkt(8'hFF, 8'h00, 5, 4);
    settle();
    check("commit_pulses", 32'(obs_commit - c0), 1);
    check("commit_no_wr", 32'(obs_wr - w0), 0);

    snap();
    send_pkt(8'h40, 8'h12, 5, 4);
    settle();
    check("badaddr_err", 32'(obs_err - e0), 1);
    check("badaddr_cnt", 32'(error_count_out), 1);
    check("badaddr_no_wr", 32'(obs_wr - w0), 0);
    send_pkt(8'h3F, 8'h01, 5, 4);
    settle();
    check("addr63", 32'(wr_addr_out), 32'h3F);
    check("addr63_data", 32'(wr_data_out), 32'h01);

    snap();
    send_byte(8'hAA, 3, 4);
    send_byte(8'h03, 3, 4);
    repeat (T + 100) @(negedge clock_in);
    check("timeout_err", 32'(obs_err - e0), 1);
    check("timeout_cnt", 32'(error_count_out), 2);
    check("timeout_idle", 32'(busy_out), 0);
    check("timeout_delay", 32'(last_err_cyc - last_strb_cyc), T);
    send_pkt(8'h03, 8'h10, 4, 3);
    settle();
    check("post_timeout_addr", 32'(wr_addr_out), 32'h03);
    check("post_timeout_data", 32'(wr_data_out), 32'h10);

`ifdef UART_CMD_CHECKSUM_EN
    snap();
    send_byte(8'hAA, 3, 3); send_byte(8'h05, 3, 3);
    send_byte(8'h7F, 3, 3); send_byte(8'h00, 3, 3);
    settle();
    check("csum_err", 32'(obs_err - e0), 1);
    check("csum_no_wr", 32'(obs_wr - w0), 0);
`endif

    snap();
    send_byte(8'h00, 4, 3); send_byte(8'h55, 4, 3); send_byte(8'hFF, 4, 3);
    settle();
    check("garbage_strobes", 32'((obs_wr - w0) + (obs_commit - c0) + (obs_err - e0)), 0);
    check("garbage_busy", 32'(busy_out), 0);

    snap();
    send_byte(8'hAA, 3, 3); send_byte(8'h05, 3, 3);
    @(negedge clock_in);
    reset_in = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_out), 0);
    check("midrst_cnt", 32'(error_count_out), 0);
    repeat (3) @(negedge clock_in);
    reset_in = 1'b0;
    settle();
    check("midrst_no_strobe", 32'((obs_wr - w0) + (obs_commit - c0) + (obs_err - e0)), 0);
    send_pkt(8'h01, 8'h02, 3, 3);
    settle();
    check("post_rst_addr", 32'(wr_addr_out), 32'h01);
    check("post_rst_data", 32'(wr_data_out), 32'h02);

    // Randomized packet mix checked by the reference model.
    for (int i = 0; i < 150; i++) begin
      int kind, hold, gap;
      logic [7:0] a, d;
      kind = int'($urandom_range(0, 5));
      hold = int'($urandom_range(1, 12));
      gap  = int'($urandom_range(2, 8));
      d    = 8'($urandom);
      case (kind)
        0: send_pkt(8'($urandom_range(0, 63)), d, hold, gap);
        1: send_pkt(8'hFF, d, hold, gap);
        2: send_pkt(8'($urandom_range(64, 254)), d, hold, gap);
        3: begin
          a = 8'($urandom);
          if (a == 8'hAA) a = 8'h00;
          send_byte(a, hold, gap);
        end
        4: begin
          send_byte(8'hAA, hold, gap);
          send_byte(8'($urandom_range(0, 63)), hold, gap);
          send_byte(d, hold, gap);
`ifdef UART_CMD_CHECKSUM_EN
          send_byte(8'($urandom), hold, gap);
`endif
        end
        default: send_pkt(8'($urandom), d, hold, gap);
      endcase
    end
    settle();

    for (int i = 0; i < 300; i++) send_pkt(8'h80, 8'($urandom), 1, 2);
    settle();
    check("err_saturate", 32'(error_count_out), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_sequencer.md
Name: uart_cmd_sequencer

Overview:
- Consumes the byte stream from the UART receiver and frames it into transducer-phase commands.
- Validates each packet and issues single-cycle writes into the phase register file.
- Issues a commit strobe that transfers shadow phases to active phases.
- Sits between uart_rx and the phase register bank / PWM generator array.

Parameters:
- NUM_CHANNELS, 64, number of transducer channels; valid addresses are 0..NUM_CHANNELS-1.
- ADDR_WIDTH, 6, width of wr_addr_out; must satisfy 2^ADDR_WIDTH >= NUM_CHANNELS.
- SYNC_BYTE, 8'hAA, packet start marker.
- COMMIT_ADDR, 8'hFF, address value that means "commit" instead of "write".
- TIMEOUT_CYCLES, 4096, maximum clocks allowed between bytes inside a packet; 16-bit counter.

Ports:
- clock_in  input  1  system clock, same as uart_rx.
- reset_in  input  1  asynchronous, active-high reset.
- rx_done_in  input  1  uart_rx done level; stays high for most of the stop bit.
- rx_byte_in  input  8  uart_rx received byte; stable while rx_done_in is high.
- wr_en_out  output  1  one-cycle phase write strobe.
- wr_addr_out  output  ADDR_WIDTH  channel index for the write.
- wr_data_out  output  8  phase value for the write.
- commit_out  output  1  one-cycle shadow-to-active strobe.
- error_out  output  1  one-cycle strobe on any rejected packet.
- error_count_out  output  8  saturating count of rejected packets.
- busy_out  output  1  high in any state except IDLE.

Behaviour:
- Reset (async, reset_in=1): state=IDLE; all outputs 0; internal byte registers, rx_done_q and timeout counter all 0.
- Byte strobe: strb = rx_done_in & ~rx_done_q, where rx_done_q is rx_done_in registered. This gives exactly one strobe per received byte regardless of how long done is held high. rx_byte_in is captured on the strb cycle.
- States and transitions:
  - IDLE: on strb with byte==SYNC_BYTE go to ADDR. Any other byte is discarded silently, with no error.
  - ADDR: on strb capture addr, go to DATA. A second SYNC_BYTE here is treated as an ordinary address byte; no resync.
  - DATA: on strb capture data. Go to CSUM if CHECKSUM_EN is defined, else go to EXEC.
  - CSUM: on strb capture csum, go to EXEC.
  - EXEC (1 cycle, always returns to IDLE):
    - If the packet is invalid: error_out=1 and error_count_out increments, saturating at 255.
    - Else if addr==COMMIT_ADDR: commit_out=1; data is ignored.
    - Else: wr_en_out=1, wr_addr_out=addr[ADDR_WIDTH-1:0], wr_data_out=data.
- Packet invalid when addr >= NUM_CHANNELS and addr != COMMIT_ADDR, or on a checksum mismatch (CHECKSUM_EN only).
- Latency: strobes assert exactly 2 clocks after the rising edge of rx_done_in for the final byte (1 cycle strb, 1 cycle EXEC register).
- Output hold: wr_addr_out and wr_data_out hold their last written values between writes. Strobes are high for exactly one cycle.
- Timeout:
  - Counter clears in IDLE and on every strb; otherwise it increments in ADDR/DATA/CSUM.
  - When it reaches TIMEOUT_CYCLES-1 without a strb: error_out=1, error_count_out increments, state=IDLE.
  - If a strb arrives on that same cycle, the strb wins and there is no timeout.
- Simultaneous events: only one of wr_en_out/commit_out/error_out can be high in a cycle. A strb during EXEC cannot occur, because bytes are at least 10 bit-times apart.
- Reset mid-packet: the partial packet is dropped, no strobes, error_count_out returns to 0.
- busy_out is combinational from state (state != IDLE).

Optional Feature:
- Macro: UART_CMD_CHECKSUM_EN.
- Defined: 4-byte packet SYNC, ADDR, DATA, CSUM. Required CSUM = SYNC_BYTE ^ addr ^ data; a mismatch rejects the packet in EXEC, with no write and no commit.
- Undefined: 3-byte packet SYNC, ADDR, DATA. The CSUM state is not synthesized and checksum logic is absent.

Test Plan:
- Write: bytes AA,05,7F (+ checksum D0 if enabled), each with done held 127 cycles -> one wr_en_out pulse, wr_addr_out=5, wr_data_out=0x7F, no error, error_count_out=0.
- Commit: AA,FF,00 (+55) -> one commit_out pulse, no wr_en_out.
- Bad address: AA,40,12 (+F8) -> error_out pulse, error_count_out=1, no write. Next valid packet AA,3F,01 (+94) writes addr 63.
- Timeout: AA,03, then silence for 4096 cycles -> error_out pulse about 4095 cycles after the last strb, state IDLE. A following AA,03,10 writes normally.
- Checksum (enabled only): AA,05,7F,00 -> error_out, no write. Also: 300 bad packets -> error_count_out saturates at 255.
- Reset: assert reset_in after AA,05 -> busy_out=0 immediately, no strobe. Then AA,01,02 (+A9) -> write addr1 data 0x02. Also: garbage bytes 00,55,FF sent in IDLE -> no strobes.
